// File: rtl/x_100_from_mod_997.sv
// Rebuilds a 100-bit operand from its mod-997 decomposition, X = Q*997 + R,
// using a 10-step constant shift-add sequence with valid/ready handshakes.
module x_100_from_mod_997 #(
   parameter int MOD = 997,
   parameter int QW  = 91,
   parameter int RW  = 10,
   parameter int XW  = 100,
   parameter int AW  = 102
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [QW-1:0] Q,
   input  logic [RW-1:0] R,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [XW-1:0] X,
   output logic          err_range,
   output logic          err_ovf
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   localparam logic [9:0]    MOD_BITS = 10'(MOD);
   localparam logic [RW-1:0] MOD_RW   = RW'(MOD);

   state_t          state_q, state_d;
   logic [3:0]      k_q, k_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [QW-1:0]   qreg_q, qreg_d;
   logic            rng_r_q, rng_r_d;
   logic [XW-1:0]   x_q, x_d;
   logic            rng_q, rng_d;
   logic            ovf_q, ovf_d;
   logic [AW-1:0]   addend;

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      acc_d    = acc_q;
      qreg_d   = qreg_q;
      rng_r_d  = rng_r_q;
      x_d      = x_q;
      rng_d    = rng_q;
      ovf_d    = ovf_q;
      addend   = {{(AW-QW){1'b0}}, qreg_q} << k_q;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               qreg_d  = Q;
               acc_d   = {{(AW-RW){1'b0}}, R};
               rng_r_d = (R >= MOD_RW);
               k_d     = 4'd0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (MOD_BITS[k_q]) acc_d = acc_q + addend;
            // Results are latched into the output registers on the last step so
            // they survive the accumulator being reloaded by the next operand.
            if (k_q == 4'd9) begin
               k_d     = 4'd0;
               x_d     = acc_d[XW-1:0];
               ovf_d   = |acc_d[AW-1:XW];
               rng_d   = rng_r_q;
               state_d = S_DONE;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= 4'd0;
         acc_q   <= '0;
         qreg_q  <= '0;
         rng_r_q <= 1'b0;
         x_q     <= '0;
         rng_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         qreg_q  <= qreg_d;
         rng_r_q <= rng_r_d;
         x_q     <= x_d;
         rng_q   <= rng_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = (state_q == S_DONE);
   assign X         = x_q;
   assign err_range = rng_q;
   assign err_ovf   = ovf_q;

endmodule

// File: tb/tb_x_100_from_mod_997.sv
// Self-checking bench for x_100_from_mod_997: directed and random transactions
// compared against an arithmetic model of Q*997 + R.
module tb_x_100_from_mod_997;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [90:0]  Q;
   logic [9:0]   R;
   logic         out_valid;
   logic         out_ready;
   logic [99:0]  X;
   logic         err_range;
   logic         err_ovf;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int acc_cyc;
   int prev_acc;

   x_100_from_mod_997 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Q         (Q),
      .R         (R),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .X         (X),
      .err_range (err_range),
      .err_ovf   (err_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL global_timeout: sim time exceeded");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] model_full(input logic [90:0] q, input logic [9:0] r);
      return 128'(q) * 128'd997 + 128'(r);
   endfunction

   function automatic logic [90:0] rand_q();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[90:0];
   endfunction

   // One full transaction: accept, count latency, check result, optional hold in DONE.
   task automatic txn(input string tag, input logic [90:0] q, input logic [9:0] r,
                      input int hold, input bit poke);
      logic [127:0] full;
      logic [99:0]  xs;
      int w;
      int n;
      bit rdy_seen;
      full = model_full(q, r);
      w = 0;
      while (!in_ready && w < 50) begin tick(); w++; end
      if (w >= 50) check({tag, "_ready_wait"}, 0, 1);
      in_valid = 1'b1; Q = q; R = r;
      tick();
      prev_acc = acc_cyc;
      acc_cyc  = cyc;
      in_valid = 1'b0; Q = rand_q(); R = 10'($urandom());
      n = 0; rdy_seen = 0;
      while (!out_valid && n < 40) begin
         if (in_ready) rdy_seen = 1;
         if (n == 3) begin in_valid = 1'b1; Q = rand_q(); end
         tick();
         in_valid = 1'b0;
         n++;
      end
      check({tag, "_latency"}, n, 10);
      check({tag, "_ready_calc"}, rdy_seen, 0);
      check({tag, "_X"}, X, full[99:0]);
      check({tag, "_err_range"}, err_range, (r >= 10'd997));
      check({tag, "_err_ovf"}, err_ovf, (full >= (128'd1 << 100)));
      xs = X;
      for (int h = 0; h < hold; h++) begin
         if (poke && h == 1) begin in_valid = 1'b1; Q = 91'd5; R = 10'd0; end
         tick();
         in_valid = 1'b0;
         check({tag, "_hold_X"}, X, xs);
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_drop_valid"}, out_valid, 0);
      check({tag, "_idle_ready"}, in_ready, 1);
      check({tag, "_keep_X"}, X, xs);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Q = '0; R = '0;
      acc_cyc = 0; prev_acc = 0;
      tick(); tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_X", X, 0);
      check("rst_flags", {err_range, err_ovf}, 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", in_ready, 1);

      txn("zero", 91'd0, 10'd0, 0, 0);
      txn("q1r996", 91'd1, 10'd996, 0, 0);
      check("q1r996_X_const", X, 1993);
      txn("q2r7", 91'd2, 10'd7, 0, 0);
      check("q2r7_X_const", X, 2001);
      check("b2b_interval", acc_cyc - prev_acc, 12);
      txn("q2p90", 91'd1 << 90, 10'd5, 0, 0);
      check("q2p90_ovf_const", err_ovf, 0);
      txn("qmax", {91{1'b1}}, 10'd0, 0, 0);
      check("qmax_ovf_const", err_ovf, 1);
      txn("q3r997", 91'd3, 10'd997, 0, 0);
      check("q3r997_X_const", X, 3988);
      check("q3r997_rng_const", {err_range, err_ovf}, 2'b10);
      txn("hold", 91'd10, 10'd1, 5, 1);
      check("hold_X_const", X, 9971);
      tick(); tick();
      check("poke_ignored", out_valid, 0);

      // Reset in the middle of CALC discards the result.
      in_valid = 1'b1; Q = 91'd77; R = 10'd3;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_X", X, 0);
      check("midrst_flags", {err_range, err_ovf}, 0);
      check("midrst_ready", in_ready, 1);
      begin
         bit seen;
         seen = 0;
         for (int i = 0; i < 15; i++) begin tick(); if (out_valid) seen = 1; end
         check("midrst_no_output", seen, 0);
      end
      txn("after_rst", 91'd2, 10'd7, 0, 0);
      check("after_rst_X_const", X, 2001);

      for (int i = 0; i < 25; i++) begin
         logic [90:0] rq;
         logic [9:0]  rr;
         rq = rand_q();
         if (i % 4 == 0) rq[90:80] = 11'h7FF;
         rr = 10'($urandom_range(0, 1023));
         txn($sformatf("rnd%0d", i), rq, rr, int'($urandom_range(0, 2)), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/x_100_from_mod_997.md
Name: x_100_from_mod_997

Overview:
Reconstructs a 100-bit operand from its mod-997 decomposition, computing X = Q*997 + R. This is the inverse of the 100-bit mod-997 reducer. It is used in the modular datapath to rebuild operands and to self-check the reducer, where R = X mod 997 and Q = floor(X/997). The block is a sequential constant-multiply shift-add unit with valid/ready handshakes on input and output.

Parameters:
MOD, 997, modulus constant; the multiplier bit pattern is 1111100101b.
QW, 91, quotient width; ceil(log2((2^100-1)/997 + 1)) = 91.
RW, 10, residue width.
XW, 100, output width.
AW, 102, internal accumulator width, guaranteeing no internal overflow.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  Q/R offered.
in_ready  output  1  block can accept; high only in IDLE.
Q  input  [91:1]  quotient.
R  input  [10:1]  residue.
out_valid  output  1  result X and flags valid.
out_ready  input  1  consumer accepts the result.
X  output  [100:1]  reconstructed value, low 100 bits of Q*997+R.
err_range  output  1  captured R was >= 997.
err_ovf  output  1  Q*997+R >= 2^100, so X is truncated.

Behaviour:
- Reset: rst is sampled on clk.
  - State goes to IDLE; step counter k = 0; accumulator = 0.
  - X = 0, out_valid = 0, err_range = 0, err_ovf = 0.
  - in_ready = 0 while rst is high; it is 1 in the first cycle after rst deasserts.
  - rst overrides every other event, including mid-CALC and DONE with out_ready high. Any in-flight result is discarded with no output.
- State machine IDLE -> CALC -> DONE -> IDLE:
  - IDLE: in_ready = 1. On an edge with in_valid = 1:
    - Q is captured into qreg.
    - The accumulator is loaded with zero-extended R.
    - err_range_r is set to (R >= 997).
    - k = 0; go to CALC.
    - in_valid low: stay in IDLE.
  - CALC: in_ready = 0. On each edge:
    - If bit k of 997 is set (k in {0,2,5,6,7,8,9}), acc <= acc + (qreg << k), using 102-bit arithmetic.
    - k increments; after the k = 9 step, go to DONE.
    - CALC always takes exactly 10 edges, regardless of operand values.
  - DONE: out_valid = 1.
    - X = acc[100:1].
    - err_ovf = |acc[102:101].
    - err_range = err_range_r.
    - Outputs are held stable while out_ready = 0.
    - On an edge with out_ready = 1: go to IDLE. out_valid drops in the next cycle.
- Latency and throughput:
  - out_valid is first high in the 10th cycle after the accepting edge, i.e. the accept edge plus 10 edges.
  - No input bypass: in_ready is 0 in DONE, and the next input can be accepted no earlier than the first IDLE cycle.
  - Minimum initiation interval is 12 cycles.
- Inputs are ignored outside IDLE: in_valid, Q and R changes during CALC or DONE have no effect.
- err_range does not abort the computation: the arithmetic result with out-of-range R is still produced.
- err_ovf and truncation are independent of err_range; both flags may be set together.
- X, err_range and err_ovf hold their last values when out_valid = 0. They are cleared only by rst.

Test Plan:
1. Reset, then Q=0, R=0 -> X=0, err_range=0, err_ovf=0. out_valid rises in the 10th cycle after acceptance, and in_ready=0 during CALC and DONE.
2. Q=1, R=996 -> X=1993, no flags. Then Q=2, R=7 sent back-to-back -> X=2001, accepted no earlier than 12 cycles after the first acceptance.
3. Q=2^90, R=5 -> X=(997<<90)+5, err_ovf=0. Then Q=2^91-1, R=0 -> err_ovf=1 and X = low 100 bits of 997*(2^91-1).
4. Q=3, R=997 -> err_range=1, err_ovf=0, X=3988.
5. Q=10, R=1 with out_ready held low for 5 cycles in DONE -> X=9971 stable throughout. in_ready=0, and an in_valid pulse with Q=5 is ignored. out_ready=1 -> IDLE on the next cycle.
6. rst asserted for 1 cycle at k=4 of CALC -> out_valid=0 and X=0, with no result emitted. The next transaction Q=2, R=7 -> X=2001, flags 0.
